key_loader: RTL and testbench

Upstream stage of the simple XOR encryption block. It assembles a 64-bit key from a narrow 16-bit load bus and presents it atomically on a stable key register. Once software sets the lock, the key cannot be modified or read back; only zeroize or reset clears it. The encryptor samples `key` every cycle, so this block guarantees `key` changes only on a completed, well-formed load, lock-release by zeroize, or reset.

---
 rtl/key_loader_pkg.sv | 19 +
 rtl/key_loader.sv | 117 +++++++++++
 tb/tb_key_loader.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/key_loader_pkg.sv
// Shared types and default sizing for the key loader.
// The loader assembles a wide key from narrow load-bus beats.
package key_loader_pkg;

    localparam int unsigned BEAT_W_DEF = 16;
    localparam int unsigned KEY_W_DEF  = 64;

    typedef enum logic [1:0] {
        KL_IDLE,
        KL_LOAD,
        KL_ARMED,
        KL_LOCKED
    } kl_state_t;

    function automatic int unsigned nbeats(input int unsigned key_w, input int unsigned beat_w);
        return key_w / beat_w;
    endfunction

endpackage

// File: rtl/key_loader.sv
// Assembles a KEY_W key from BEAT_W beats and presents it atomically on a registered output.
// Supports lock (freeze until zeroize/reset) and zeroize (clear all key material).
module key_loader
    import key_loader_pkg::*;
#(
    parameter int unsigned BEAT_W = BEAT_W_DEF,
    parameter int unsigned KEY_W  = KEY_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              kl_valid,
    input  logic [BEAT_W-1:0] kl_data,
    input  logic              kl_last,
    output logic              kl_ready,
    input  logic              lock,
    input  logic              zeroize,
    output logic [KEY_W-1:0]  key,
    output logic              key_valid,
    output logic              locked,
    output logic              err
);

    localparam int unsigned NBEATS = nbeats(KEY_W, BEAT_W);
    localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    kl_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [KEY_W-1:0]  shadow_q, shadow_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic              key_valid_q, key_valid_d;
    logic              locked_q, locked_d;
    logic              err_q, err_d;

    logic              beat_accept;
    logic              final_beat;
    logic              malformed;
    logic [KEY_W-1:0]  assembled;

    assign kl_ready    = (state_q != KL_LOCKED) && !zeroize;
    assign beat_accept = kl_valid && kl_ready;
    assign final_beat  = (cnt_q == LAST_BEAT);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        locked_d    = locked_q;
        err_d       = 1'b0;
        malformed   = 1'b0;

        assembled = shadow_q;
        assembled[(NBEATS-1)*BEAT_W +: BEAT_W] = kl_data;

        if (zeroize) begin
            state_d     = KL_IDLE;
            cnt_d       = '0;
            shadow_d    = '0;
            key_d       = '0;
            key_valid_d = 1'b0;
            locked_d    = 1'b0;
        end else if (beat_accept) begin
            // kl_last must coincide exactly with the final beat slot
            malformed = final_beat ? !kl_last : kl_last;
            if (malformed) begin
                err_d    = 1'b1;
                shadow_d = '0;
                cnt_d    = '0;
                state_d  = key_valid_q ? KL_ARMED : KL_IDLE;
            end else if (final_beat) begin
                key_d       = assembled;
                key_valid_d = 1'b1;
                shadow_d    = '0;
                cnt_d       = '0;
                state_d     = KL_ARMED;
            end else begin
                shadow_d[int'(cnt_q) * BEAT_W +: BEAT_W] = kl_data;
                cnt_d = cnt_q + CNT_W'(1);
                if (state_q == KL_IDLE) begin
                    state_d = KL_LOAD;
                end
            end
        end else if (lock && (state_q == KL_ARMED)) begin
            // A beat in the same cycle wins; lock must be reasserted afterwards
            state_d  = KL_LOCKED;
            locked_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= KL_IDLE;
            cnt_q       <= '0;
            shadow_q    <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
        end
    end

    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign locked    = locked_q;
    assign err       = err_q;

endmodule

// File: tb/tb_key_loader.sv
// Scoreboard bench for key_loader: a beat-queue reference model predicts outputs per cycle,
// a negedge monitor pops and compares.
module tb_key_loader;

    localparam int BW = 16;
    localparam int KW = 64;
    localparam int NB = KW / BW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          kl_valid = 1'b0;
    logic [BW-1:0] kl_data = '0;
    logic          kl_last = 1'b0;
    logic          kl_ready;
    logic          lock = 1'b0;
    logic          zeroize = 1'b0;
    logic [KW-1:0] key;
    logic          key_valid;
    logic          locked;
    logic          err;

    key_loader #(.BEAT_W(BW), .KEY_W(KW)) dut (
        .clk       (clk),
        .rst       (rst),
        .kl_valid  (kl_valid),
        .kl_data   (kl_data),
        .kl_last   (kl_last),
        .kl_ready  (kl_ready),
        .lock      (lock),
        .zeroize   (zeroize),
        .key       (key),
        .key_valid (key_valid),
        .locked    (locked),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [KW-1:0] key;
        logic          kv;
        logic          lk;
        logic          er;
        logic          rdy;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_push   = 0;
    int   n_pop    = 0;

    // Reference model: accepted beats collected in a queue, key built when the set is complete
    logic [KW-1:0] m_key;
    bit            m_kv, m_lk, m_err;
    logic [BW-1:0] m_beats[$];

    task automatic chk(input string nm, input logic [KW-1:0] act, input logic [KW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_key = '0;
        m_kv  = 1'b0;
        m_lk  = 1'b0;
        m_err = 1'b0;
        m_beats.delete();
    endtask

    task automatic step(input bit v, input logic [BW-1:0] d, input bit l,
                        input bit lk, input bit z, input bit r);
        exp_t e;
        @(posedge clk);
        #1;
        kl_valid = v;
        kl_data  = d;
        kl_last  = l;
        lock     = lk;
        zeroize  = z;
        rst      = r;
        if (r) model_reset();
        e.key = m_key;
        e.kv  = m_kv;
        e.lk  = m_lk;
        e.er  = m_err;
        e.rdy = !m_lk && !z;
        exp_q.push_back(e);
        n_push++;
        if (!r) begin
            if (z) begin
                model_reset();
            end else begin
                m_err = 1'b0;
                if (v && !m_lk) begin
                    m_beats.push_back(d);
                    if (m_beats.size() == NB) begin
                        if (l) begin
                            m_key = '0;
                            for (int i = 0; i < NB; i++) m_key[i*BW +: BW] = m_beats[i];
                            m_kv = 1'b1;
                        end else begin
                            m_err = 1'b1;
                        end
                        m_beats.delete();
                    end else if (l) begin
                        m_err = 1'b1;
                        m_beats.delete();
                    end
                end else if (lk && m_kv) begin
                    m_lk = 1'b1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0, 0);
    endtask

    task automatic beat(input logic [BW-1:0] d, input bit l);
        step(1, d, l, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_pop++;
            chk("key", key, mon_e.key);
            chk("key_valid", KW'(key_valid), KW'(mon_e.kv));
            chk("locked", KW'(locked), KW'(mon_e.lk));
            chk("err", KW'(err), KW'(mon_e.er));
            chk("kl_ready", KW'(kl_ready), KW'(mon_e.rdy));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit v, l, correct;
        model_reset();
        repeat (2) @(posedge clk);

        // Nominal load
        beat(16'h1111, 0); beat(16'h2222, 0); beat(16'h3333, 0); beat(16'h4444, 1);
        idle(2);
        // Early last, then recover
        beat(16'hAAAA, 0); beat(16'hBBBB, 1);
        idle(2);
        beat(16'h0C01, 0); beat(16'h0C02, 0); beat(16'h0C03, 0); beat(16'h0C04, 1);
        idle(1);
        // Reload in ARMED with a stall before the last beat
        beat(16'hB001, 0); beat(16'hB002, 0); beat(16'hB003, 0);
        idle(5);
        beat(16'hB004, 1);
        idle(2);
        // Lock, attack with beats, then zeroize
        step(0, '0, 0, 1, 0, 0);
        idle(1);
        beat(16'hDEAD, 0); beat(16'hBEEF, 0); beat(16'hCAFE, 0); beat(16'hF00D, 1);
        step(0, '0, 0, 0, 1, 0);
        idle(2);
        // Missing last, then final beat colliding with zeroize
        beat(16'h0001, 0); beat(16'h0002, 0); beat(16'h0003, 0); beat(16'h0004, 0);
        idle(2);
        beat(16'h0011, 0); beat(16'h0022, 0); beat(16'h0033, 0);
        step(1, 16'h0044, 1, 0, 1, 0);
        idle(2);
        // Back-to-back loads
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NB; i++) beat(16'(16'h5000 + k*16 + i), i == NB-1);
        // Async reset mid-load, then a clean load
        beat(16'h7777, 0); beat(16'h8888, 0);
        step(0, '0, 0, 0, 0, 1);
        step(0, '0, 0, 0, 0, 1);
        beat(16'h9001, 0); beat(16'h9002, 0); beat(16'h9003, 0); beat(16'h9004, 1);
        idle(2);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            v       = ($urandom % 100) < 60;
            correct = (m_beats.size() == NB - 1);
            l       = v && ((($urandom % 100) < 90) ? correct : !correct);
            step(v, 16'($urandom), l, ($urandom % 100) < 8, ($urandom % 100) < 2,
                 ($urandom % 1000) < 5);
        end
        idle(2);

        @(negedge clk);
        #1;
        chk("drain", KW'(n_pop), KW'(n_push));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
